rr_priority_arbiter: RTL

RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_select.sv | 30 +++
 rtl/rr_priority_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin priority arbiter.
// Build option: define RR_ARB_LOCK_EN to add the lock (winner hold) port.
package arb_pkg;

    // Arbiter state: IDLE presents nothing, GRANT presents a winner.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_select.sv
// Combinational rotate-and-encode search: first set request bit found
// walking downward from ptr with wrap-around (ptr, ptr-1, ..., 0, NUM_REQ-1, ...).
module rr_select #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int unsigned sum;
        int unsigned pos;
        any = |req;
        idx = '0;
        sum = 0;
        pos = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            sum = 32'(ptr) + NUM_REQ - 32'(k);
            pos = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
            if (req[pos]) begin
                idx = IDX_W'(pos);
            end
        end
    end

endmodule : rr_select

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with registered grant index / one-hot outputs and a
// valid/ready handshake. The granted requester becomes lowest priority.
// Build option: RR_ARB_LOCK_EN adds a lock input that re-grants the same
// requester on a handshake while it keeps requesting.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [NUM_REQ-1:0] out_onehot
);

    arb_state_e        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  adv_ptr;
    logic [IDX_W-1:0]  sel_ptr;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic              handshake;
    logic              hold;

    assign out_valid = (state == GRANT);
    assign handshake = out_valid & out_ready;

    // Pointer after a handshake: one below the granted index, wrapping to the top.
    assign adv_ptr = (out_idx == '0) ? IDX_W'(NUM_REQ - 1) : (out_idx - 1'b1);

`ifdef RR_ARB_LOCK_EN
    // Lock only holds the winner while that requester is still asking.
    assign hold = lock & req[out_idx];
`else
    assign hold = 1'b0;
`endif

    // On an advancing handshake the next winner is searched from the updated pointer.
    assign sel_ptr = (handshake && !hold) ? adv_ptr : ptr;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req (req),
        .ptr (sel_ptr),
        .any (sel_any),
        .idx (sel_idx)
    );

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            out_idx    <= '0;
            out_onehot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state      <= GRANT;
                        out_idx    <= sel_idx;
                        out_onehot <= NUM_REQ'(1) << sel_idx;
                    end
                end
                GRANT: begin
                    if (out_ready && !hold) begin
                        ptr <= adv_ptr;
                        if (sel_any) begin
                            out_idx    <= sel_idx;
                            out_onehot <= NUM_REQ'(1) << sel_idx;
                        end else begin
                            state      <= IDLE;
                            out_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    out_onehot <= '0;
                end
            endcase
        end
    end

endmodule : rr_priority_arbiter
